// File: rtl/stack_pop_unit_if.sv
// Request/response and stack-memory read signals of stack_pop_unit.
// The peek_req signal exists only when STACK_POP_PEEK_EN is defined.
interface stack_pop_unit_if #(
  parameter int ADDR_W = 5
);
  logic              pop_req;
  logic [31:0]       esp_in;
  logic              pop_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic [31:0]       pop_data;
  logic              pop_valid;
  logic [31:0]       esp_out;
  logic              esp_we;
  logic              underflow;
  logic [2:0]        dbg_state;
`ifdef STACK_POP_PEEK_EN
  logic              peek_req;
`endif

  // Handshake: a request (pop_req, or peek_req when enabled) is taken on the
  // rising edge where pop_ready=1; requests seen while pop_ready=0 are dropped,
  // never queued. pop_valid, esp_we and underflow are single-cycle pulses.
  modport master (
    output pop_req, esp_in, mem_rd_data,
`ifdef STACK_POP_PEEK_EN
    output peek_req,
`endif
    input  pop_ready, mem_rd_en, mem_rd_addr, pop_data, pop_valid,
    input  esp_out, esp_we, underflow, dbg_state
  );

  modport slave (
    input  pop_req, esp_in, mem_rd_data,
`ifdef STACK_POP_PEEK_EN
    input  peek_req,
`endif
    output pop_ready, mem_rd_en, mem_rd_addr, pop_data, pop_valid,
    output esp_out, esp_we, underflow, dbg_state
  );
endinterface

// File: rtl/stack_pop_unit.sv
// Stack pop unit: reads the word at esp, returns it and writes back esp+1.
// Optional non-destructive peek is enabled with the STACK_POP_PEEK_EN macro.
module stack_pop_unit #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  stack_pop_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t            state;
  logic [31:0]       esp_lat;
  logic              is_pop;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_rd_addr_q;
  logic [31:0]       pop_data_q;
  logic              pop_valid_q;
  logic [31:0]       esp_out_q;
  logic              esp_we_q;
  logic              underflow_q;
  logic              start;

`ifdef STACK_POP_PEEK_EN
  assign start = bus.pop_req | bus.peek_req;
`else
  assign start = bus.pop_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      esp_lat       <= 32'd0;
      is_pop        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      pop_data_q    <= 32'd0;
      pop_valid_q   <= 1'b0;
      esp_out_q     <= 32'd0;
      esp_we_q      <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      mem_rd_en_q <= 1'b0;
      pop_valid_q <= 1'b0;
      esp_we_q    <= 1'b0;
      underflow_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bus.esp_in < DEPTH_W) begin
              // pop_req wins over peek_req when both are high
              esp_lat       <= bus.esp_in;
              is_pop        <= bus.pop_req;
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= bus.esp_in[ADDR_W-1:0];
              state         <= S_READ;
            end else begin
              underflow_q <= 1'b1;
              state       <= S_ERR;
            end
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          pop_data_q  <= bus.mem_rd_data;
          pop_valid_q <= 1'b1;
          esp_we_q    <= is_pop;
          if (is_pop) esp_out_q <= esp_lat + 32'd1;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pop_ready   = (state == S_IDLE);
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.pop_data    = pop_data_q;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.esp_out     = esp_out_q;
  assign bus.esp_we      = esp_we_q;
  assign bus.underflow   = underflow_q;
  assign bus.dbg_state   = state;

endmodule

// File: doc/stack_pop_unit.md
STACK_POP_UNIT -- requirements
Module: stack_pop_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit stack words; legal esp range is 0..DEPTH-1.
REQ-002 SHALL have parameter ADDR_W, default 5, stack memory address width (log2 DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset, sampled on clock rising edge.
REQ-005 pop_req  in  1  pop request, sampled only while pop_ready=1.
REQ-006 esp_in  in  32  current stack pointer (word index), sampled with an accepted pop_req.
REQ-007 mem_rd_data  in  32  stack memory read data, valid one cycle after mem_rd_en.
REQ-008 pop_ready  out  1  unit idle, request will be accepted.
REQ-009 mem_rd_en  out  1  one-cycle stack memory read strobe.
REQ-010 mem_rd_addr  out  ADDR_W  stack memory read address.
REQ-011 pop_data  out  32  last popped word.
REQ-012 pop_valid  out  1  one-cycle pulse, pop_data freshly updated.
REQ-013 esp_out  out  32  updated stack pointer.
REQ-014 esp_we  out  1  one-cycle pulse, write esp_out back to esp.
REQ-015 underflow  out  1  one-cycle pulse, pop rejected because the stack is empty.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT, DONE, ERR; pop_ready=1 only in IDLE.
REQ-017 IDLE: pop_req=1 with esp_in<DEPTH at edge E0 SHALL latch esp_in and go to READ; with esp_in>=DEPTH SHALL go to ERR; pop_req=0 stays IDLE.
REQ-018 READ (cycle after E0): mem_rd_en=1, mem_rd_addr=latched esp[ADDR_W-1:0]; next state WAIT unconditionally.
REQ-019 WAIT: mem_rd_en=0; at the closing edge pop_data SHALL capture mem_rd_data; next state DONE.
REQ-020 DONE: pop_valid=1, esp_we=1, esp_out=latched esp+1 (32-bit, no wrap check); next state IDLE.
REQ-021 ERR: underflow=1 for exactly one cycle; no mem_rd_en, no esp_we, pop_data unchanged; next state IDLE.
REQ-022 Latency: pop_valid SHALL assert in the third cycle after the acceptance edge; back-to-back pops SHALL be spaced at least 4 cycles.
REQ-023 pop_req while pop_ready=0 SHALL be ignored, not queued.
REQ-024 esp_in changes after acceptance SHALL NOT affect the operation in progress.
REQ-025 esp_in=DEPTH-1 SHALL pop normally and produce esp_out=DEPTH; the next pop with that esp SHALL underflow.
REQ-026 pop_data SHALL hold its value between pops; esp_out SHALL hold its last value when esp_we=0.

Reset
REQ-027 Reset SHALL force IDLE at the next edge, aborting any operation with no esp_we, pop_valid or underflow pulse.
REQ-028 Reset values: pop_ready=1 (after the reset edge), mem_rd_en=0, mem_rd_addr=0, pop_data=0, pop_valid=0, esp_out=0, esp_we=0, underflow=0.
REQ-029 Reset SHALL take priority over pop_req in the same cycle.

Configuration
REQ-030 Macro STACK_POP_PEEK_EN defined: SHALL add input peek_req (1 bit); in IDLE, peek_req=1 with pop_req=0 SHALL run the same READ/WAIT/DONE sequence with pop_valid=1 but esp_we=0 and esp_out unchanged; pop_req=1 wins when both are high; an empty-stack peek SHALL go to ERR.
REQ-031 Macro undefined: port peek_req SHALL be absent and behaviour SHALL be exactly REQ-016..REQ-029.

Verification
REQ-032 Reset, then pop_req=1 with esp_in=3 and mem[3]=32'hDEAD_BEEF -> mem_rd_addr=3 in the READ cycle; pop_data=32'hDEADBEEF, pop_valid=1, esp_we=1, esp_out=4 exactly 3 cycles after acceptance.
REQ-033 pop_req=1 with esp_in=32 -> underflow=1 for one cycle, mem_rd_en and esp_we never assert, pop_ready=1 two cycles after acceptance.
REQ-034 pop_req held high continuously with esp_in=0 -> exactly one pop per 4 cycles, pop_valid pulses 4 cycles apart, esp_out=1 each time.
REQ-035 Reset asserted in the WAIT cycle -> no pop_valid or esp_we, pop_data=0, pop_ready=1 on the following cycle.
REQ-036 With STACK_POP_PEEK_EN, peek_req=1 and esp_in=31, mem[31]=32'h1234_5678 -> pop_data=32'h12345678, pop_valid=1, esp_we=0, esp_out unchanged.
